// File: rtl/ov7670_rgb444_capture_if.sv
// Captured-pixel stream from the OV7670 capture stage toward the SDRAM write path.
interface ov7670_rgb444_capture_if;
  logic        oFRAME_VALID;
  logic        oPIXEL_VALID;
  logic [15:0] oPIXEL_DATA;
  logic [9:0]  oX;
  logic [9:0]  oY;
  logic        oFRAME_START;
  logic        oFRAME_DONE;
  logic [7:0]  oFRAME_CNT;
  logic        oLINE_ERR;

  modport master (
    output oFRAME_VALID, oPIXEL_VALID, oPIXEL_DATA, oX, oY,
           oFRAME_START, oFRAME_DONE, oFRAME_CNT, oLINE_ERR
  );

  modport slave (
    input  oFRAME_VALID, oPIXEL_VALID, oPIXEL_DATA, oX, oY,
           oFRAME_START, oFRAME_DONE, oFRAME_CNT, oLINE_ERR
  );
endinterface

// File: rtl/ov7670_rgb444_capture.sv
// OV7670 RGB444 capture: waits for sensor config, drops settling frames,
// pairs bytes into 16-bit pixels and tags them with X/Y and frame markers.
module ov7670_rgb444_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SKIP_FRAMES = 10
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic                    iCONFIG_DONE,
  input  logic                    iCMOS_VSYNC,
  input  logic                    iCMOS_HREF,
  input  logic [7:0]              iCMOS_DATA,
  ov7670_rgb444_capture_if.master pix
);
  localparam logic [2:0] S_WAIT_CFG = 3'd0;
  localparam logic [2:0] S_WAIT_VS  = 3'd1;
  localparam logic [2:0] S_SKIP     = 3'd2;
  localparam logic [2:0] S_ARM      = 3'd3;
  localparam logic [2:0] S_ACTIVE   = 3'd4;

  localparam logic [9:0]  H_LIM     = 10'(H_ACTIVE);
  localparam logic [9:0]  V_LIM     = 10'(V_ACTIVE);
  localparam logic [15:0] SKIP_LAST = 16'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);
  localparam bit          NO_SKIP   = (SKIP_FRAMES == 0);

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'd1023) ? v : v + 10'd1;
  endfunction

  logic        cfg_meta_q, cfg_meta_d;
  logic        cfg_s_q, cfg_s_d;
  logic        vs_q, vs_d;
  logic        href_q, href_d;
  logic [2:0]  state_q, state_d;
  logic [15:0] skip_cnt_q, skip_cnt_d;
  logic        phase_q, phase_d;
  logic [7:0]  hi_byte_q, hi_byte_d;
  logic [9:0]  col_q, col_d;
  logic [9:0]  row_q, row_d;
  logic        frame_valid_q, frame_valid_d;
  logic        pix_valid_q, pix_valid_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_done_q, frame_done_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        line_err_q, line_err_d;

  logic vs_rise, vs_fall, href_fall;

  assign vs_rise   =  iCMOS_VSYNC & ~vs_q;
  assign vs_fall   = ~iCMOS_VSYNC &  vs_q;
  assign href_fall = ~iCMOS_HREF  &  href_q;

  always_comb begin
    cfg_meta_d    = iCONFIG_DONE;
    cfg_s_d       = cfg_meta_q;
    vs_d          = iCMOS_VSYNC;
    href_d        = iCMOS_HREF;
    state_d       = state_q;
    skip_cnt_d    = skip_cnt_q;
    phase_d       = phase_q;
    hi_byte_d     = hi_byte_q;
    col_d         = col_q;
    row_d         = row_q;
    frame_valid_d = frame_valid_q;
    pix_valid_d   = 1'b0;
    pix_data_d    = pix_data_q;
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    line_err_d    = 1'b0;

    // Losing config abandons any frame silently; the frame count is kept.
    if (!cfg_s_q) begin
      state_d       = S_WAIT_CFG;
      frame_valid_d = 1'b0;
      phase_d       = 1'b0;
    end else begin
      case (state_q)
        S_WAIT_CFG: state_d = S_WAIT_VS;
        S_WAIT_VS: begin
          if (vs_rise) begin
            skip_cnt_d = '0;
            state_d    = NO_SKIP ? S_ARM : S_SKIP;
          end
        end
        S_SKIP: begin
          if (vs_rise) begin
            if (skip_cnt_q == SKIP_LAST) state_d = S_ARM;
            else                         skip_cnt_d = skip_cnt_q + 16'd1;
          end
        end
        S_ARM: begin
          if (vs_fall) begin
            frame_start_d = 1'b1;
            frame_valid_d = 1'b1;
            x_d           = '0;
            y_d           = '0;
            col_d         = '0;
            row_d         = '0;
            phase_d       = 1'b0;
            state_d       = S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (vs_rise) begin
            // A line still open at frame end is aborted and flagged.
            frame_done_d  = 1'b1;
            frame_valid_d = 1'b0;
            frame_cnt_d   = frame_cnt_q + 8'd1;
            line_err_d    = iCMOS_HREF;
            phase_d       = 1'b0;
            col_d         = '0;
            state_d       = S_ARM;
          end else if (iCMOS_HREF) begin
            if (!phase_q) begin
              hi_byte_d = iCMOS_DATA;
              phase_d   = 1'b1;
            end else begin
              phase_d = 1'b0;
              col_d   = sat_inc(col_q);
              if (col_q < H_LIM && row_q < V_LIM) begin
                pix_valid_d = 1'b1;
                pix_data_d  = {hi_byte_q, iCMOS_DATA};
                x_d         = col_q;
                y_d         = row_q;
              end
            end
          end else begin
            phase_d = 1'b0;
            if (href_fall) begin
              line_err_d = (col_q != H_LIM) || phase_q;
              col_d      = '0;
              row_d      = sat_inc(row_q);
            end
          end
        end
        default: state_d = S_WAIT_CFG;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cfg_meta_q    <= 1'b0;
      cfg_s_q       <= 1'b0;
      vs_q          <= 1'b0;
      href_q        <= 1'b0;
      state_q       <= S_WAIT_CFG;
      skip_cnt_q    <= '0;
      phase_q       <= 1'b0;
      hi_byte_q     <= '0;
      col_q         <= '0;
      row_q         <= '0;
      frame_valid_q <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= '0;
      line_err_q    <= 1'b0;
    end else begin
      cfg_meta_q    <= cfg_meta_d;
      cfg_s_q       <= cfg_s_d;
      vs_q          <= vs_d;
      href_q        <= href_d;
      state_q       <= state_d;
      skip_cnt_q    <= skip_cnt_d;
      phase_q       <= phase_d;
      hi_byte_q     <= hi_byte_d;
      col_q         <= col_d;
      row_q         <= row_d;
      frame_valid_q <= frame_valid_d;
      pix_valid_q   <= pix_valid_d;
      pix_data_q    <= pix_data_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      frame_cnt_q   <= frame_cnt_d;
      line_err_q    <= line_err_d;
    end
  end

  assign pix.oFRAME_VALID = frame_valid_q;
  assign pix.oPIXEL_VALID = pix_valid_q;
  assign pix.oPIXEL_DATA  = pix_data_q;
  assign pix.oX           = x_q;
  assign pix.oY           = y_q;
  assign pix.oFRAME_START = frame_start_q;
  assign pix.oFRAME_DONE  = frame_done_q;
  assign pix.oFRAME_CNT   = frame_cnt_q;
  assign pix.oLINE_ERR    = line_err_q;
endmodule

// File: doc/ov7670_rgb444_capture.md
Name: ov7670_rgb444_capture

Overview:
Pixel-capture stage directly downstream of the OV7670 register-configuration block. It consumes that block's Config_Done, then decodes the camera's VSYNC/HREF/8-bit DATA bus in RGB444 (xR GB) mode. It pairs bytes into 16-bit pixels and emits them with X/Y coordinates and frame markers to the SDRAM write path. It discards the first SKIP_FRAMES frames after configuration so that AEC/AWB can settle.

Parameters:
H_ACTIVE, 640, pixels per line (each pixel is 2 bytes)
V_ACTIVE, 480, lines per frame
SKIP_FRAMES, 10, whole frames dropped after config completes (0 allowed)

Ports:
iCLK  in  1  camera PCLK; all logic on posedge
iRST_N  in  1  asynchronous, active-low reset
iCONFIG_DONE  in  1  from config block; asynchronous to iCLK
iCMOS_VSYNC  in  1  frame sync; high between frames
iCMOS_HREF  in  1  line valid; high during active bytes
iCMOS_DATA  in  8  pixel byte bus
oFRAME_VALID  out  1  high while a captured (non-skipped) frame is in progress
oPIXEL_VALID  out  1  1-cycle strobe per pixel
oPIXEL_DATA  out  16  {first byte, second byte}; [11:8]=R, [7:4]=G, [3:0]=B
oX  out  10  column of the current oPIXEL_DATA
oY  out  10  row of the current oPIXEL_DATA
oFRAME_START  out  1  1-cycle pulse at start of captured frame
oFRAME_DONE  out  1  1-cycle pulse at end of captured frame
oFRAME_CNT  out  8  captured-frame counter, wraps 255->0
oLINE_ERR  out  1  1-cycle pulse on malformed line

Behaviour:
- Reset values: all outputs 0; state WAIT_CFG; counters 0; byte phase 0.
- iCONFIG_DONE passes through a 2-flop synchronizer (cfg_s) before use. Add 2 cycles of latency.
- VSYNC and HREF are each registered once to detect edges.
  - vs_rise = VSYNC 0->1.
  - vs_fall = VSYNC 1->0.
  - href_fall = HREF 1->0.
- FSM states:
  - WAIT_CFG: idle until cfg_s=1, then go to WAIT_VS.
  - WAIT_VS: wait for vs_rise. Then go to SKIP with skip_cnt=0, or to ARM if SKIP_FRAMES=0.
  - SKIP: increment skip_cnt on each vs_rise. Go to ARM when skip_cnt reaches SKIP_FRAMES-1 on a vs_rise. No pixel or frame outputs in this state.
  - ARM: on vs_fall, pulse oFRAME_START, set oFRAME_VALID=1, clear oY/oX/phase, then go to ACTIVE.
  - ACTIVE: capture pixels. On vs_rise, pulse oFRAME_DONE, clear oFRAME_VALID, increment oFRAME_CNT, then go to ARM (continuous capture).
- cfg_s=0 in any state: go to WAIT_CFG next cycle. Clear oFRAME_VALID and phase. No oFRAME_DONE pulse. oFRAME_CNT holds its value.
- Byte pairing (ACTIVE only):
  - Phase toggles each cycle HREF=1.
  - Phase 0 latches the byte into hi_byte.
  - Phase 1 registers {hi_byte, DATA} to oPIXEL_DATA and asserts oPIXEL_VALID on the same edge. Latency is 1 edge after the second byte is sampled.
  - Phase is cleared whenever HREF=0.
- Coordinates:
  - oX/oY are registered together with the pixel.
  - The internal column counter increments after each pixel and clears on href_fall.
  - The row counter increments on each href_fall that had at least one byte.
- Suppression:
  - Pixels with column >= H_ACTIVE or row >= V_ACTIVE are not strobed (oPIXEL_VALID=0).
  - Counters saturate at 1023.
- oLINE_ERR pulses on href_fall in ACTIVE if the line's pixel count != H_ACTIVE, or if phase=1 (odd byte count; the partial byte is dropped).
- vs_rise while HREF=1:
  - The line is aborted.
  - oLINE_ERR and oFRAME_DONE pulse in the same cycle.
  - Row is not incremented.
- oPIXEL_DATA holds its last value when oPIXEL_VALID=0.
- Reset mid-frame forces the reset values immediately. Recovery requires a new cfg_s plus the full SKIP sequence.

Test Plan:
- Reset release with iCONFIG_DONE=0 and frames running -> no oPIXEL_VALID, oFRAME_START never pulses, all outputs 0.
- SKIP_FRAMES=2, config done, 4 frames of 4x2 pixels (H_ACTIVE=4, V_ACTIVE=2):
  - First oFRAME_START follows the 3rd vs_rise.
  - Exactly 8 pixel strobes per captured frame.
  - oFRAME_CNT reads 2 after the final oFRAME_DONE.
- Bytes 0x0A,0xBC,0x01,0x23 on one line -> oPIXEL_DATA=0x0ABC at X=0, then 0x0123 at X=1. Each oPIXEL_VALID occurs 1 edge after the second byte.
- Line with 7 bytes (H_ACTIVE=4) -> 3 pixels, oLINE_ERR pulses at href_fall, next line starts at X=0, oY increments.
- vs_rise during HREF=1 -> oLINE_ERR and oFRAME_DONE in the same cycle, oFRAME_VALID=0, next frame captures normally.
- iCONFIG_DONE dropped mid-frame -> oFRAME_VALID=0 within 3 cycles, no oFRAME_DONE. Re-assert -> SKIP_FRAMES frames skipped again before capture resumes.
